// File: rtl/lfsr_descramble_lock.sv
// lfsr_descramble_lock: self-synchronizing descrambler with lock tracking; optional bypass port via LFSR_DESCRAMBLE_BYPASS_EN
module lfsr_descramble_lock #(
  parameter int                    LFSR_WIDTH = 58,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 58'h8000000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = {LFSR_WIDTH{1'b1}},
  parameter int                    REVERSE    = 1,
  parameter int                    DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  input  logic                  resync,
`ifdef LFSR_DESCRAMBLE_BYPASS_EN
  input  logic                  bypass,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  data_out_locked
);
  localparam int W  = LFSR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(W + DW + 1);
  // state bit j holds the bit received j+1 bits ago, so tap x^i reads s[i-1] and x^W reads s[W-1]
  localparam logic [W-1:0] TAPS = (LFSR_POLY >> 1) | (LFSR_POLY << (W - 1));
  logic [W-1:0]  state_q, state_d, s;
  logic [DW-1:0] data_q, data_d, src, acc, rev_in, rev_acc, desc;
  logic [CW-1:0] cnt_q, cnt_d, base, sum;
  logic          valid_q, locked_q, locked_d, t;
  logic          byp;
`ifdef LFSR_DESCRAMBLE_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif
  assign rev_in  = {<<{data_in}};
  assign rev_acc = {<<{acc}};
  // serial bit-by-bit unrolled descrambler: one XOR network over {data_in, state}
  always_comb begin
    s   = state_q;
    src = (REVERSE != 0) ? data_in : rev_in;
    acc = '0;
    t   = 1'b0;
    for (int b = 0; b < DW; b++) begin
      t   = src[0] ^ (^(s & TAPS));
      acc = (acc >> 1) | (DW'(t) << (DW - 1));
      s   = (s << 1) | W'(src[0]);
      src = src >> 1;
    end
  end
  assign desc    = (REVERSE != 0) ? acc : rev_acc;
  assign state_d = data_in_valid ? s : state_q;
  assign data_d  = data_in_valid ? (byp ? data_in : desc) : data_q;
  // lock counter: resync restarts from zero, saturates at the state length
  always_comb begin
    base     = resync ? '0 : cnt_q;
    sum      = base + CW'(DW);
    cnt_d    = data_in_valid ? ((sum > CW'(W)) ? CW'(W) : sum) : base;
    locked_d = data_in_valid ? (base >= CW'(W)) : locked_q;
  end
  // registered outputs, state and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LFSR_INIT;
      data_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= data_in_valid;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end
  assign data_out        = data_q;
  assign data_out_valid  = valid_q;
  assign data_out_locked = locked_q;
endmodule

// File: tb/tb_lfsr_descramble_lock.sv
// tb_lfsr_descramble_lock: directed checks of descrambler data, lock, resync, reset and loopback
module tb_lfsr_descramble_lock;
  logic       clk = 1'b0, rst_n = 1'b0, data_in_valid = 1'b0, resync = 1'b0;
  logic [7:0] data_in = '0, data_out;
  logic       data_out_valid, data_out_locked;
`ifdef LFSR_DESCRAMBLE_BYPASS_EN
  logic       bypass = 1'b0;
`endif
  int         n_cmp = 0, n_bad = 0;
  logic [57:0] sh;
  logic [7:0]  t1 [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'h03, 8'h00, 8'h00};
  always #5 clk = ~clk;
  lfsr_descramble_lock dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid), .resync(resync),
`ifdef LFSR_DESCRAMBLE_BYPASS_EN
    .bypass(bypass),
`endif
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_locked(data_out_locked)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [7:0] d, input logic v, input logic rs);
    @(negedge clk);
    data_in = d; data_in_valid = v; resync = rs;
    @(posedge clk);
    #1;
  endtask
  task automatic scr(input logic [7:0] d, output logic [7:0] r);
    for (int b = 0; b < 8; b++) begin
      r[b] = d[b] ^ sh[38] ^ sh[57];
      sh = {sh[56:0], r[b]};
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; data_in_valid = 1'b0; resync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] d, r, exp, last;
    #12;
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", 8'(data_out_valid), 8'h00);
    chk("rst_locked", 8'(data_out_locked), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b1, 1'b0);
      chk($sformatf("t1_data%0d", i), data_out, t1[i]);
      chk($sformatf("t1_valid%0d", i), 8'(data_out_valid), 8'h01);
      chk($sformatf("t1_lock%0d", i), 8'(data_out_locked), 8'(i >= 8));
      if (i == 4) begin
        step(8'h55, 1'b0, 1'b0);
        chk("gap_valid", 8'(data_out_valid), 8'h00);
        chk("gap_hold", data_out, 8'h80);
        chk("gap_lock", 8'(data_out_locked), 8'h00);
      end
    end
    for (int i = 10; i < 30; i++) begin
      step((i == 20) ? 8'h08 : 8'h00, 1'b1, 1'b0);
      exp = (i == 20) ? 8'h08 : (i == 25) ? 8'h04 : (i == 27) ? 8'h20 : 8'h00;
      chk($sformatf("err_data%0d", i), data_out, exp);
      chk($sformatf("err_lock%0d", i), 8'(data_out_locked), 8'h01);
    end
    for (int i = 30; i < 40; i++) begin
      step(8'h00, 1'b1, i == 30);
      chk($sformatf("rs_data%0d", i), data_out, 8'h00);
      chk($sformatf("rs_lock%0d", i), 8'(data_out_locked), 8'(i >= 38));
    end
    step(8'hA5, 1'b1, 1'b0);
    chk("pre_rst_data", data_out, 8'hA5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_valid", 8'(data_out_valid), 8'h00);
    chk("mid_rst_lock", 8'(data_out_locked), 8'h00);
    data_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(8'h00, 1'b1, 1'b0);
      chk($sformatf("rr_data%0d", i), data_out, t1[i]);
      chk($sformatf("rr_lock%0d", i), 8'(data_out_locked), 8'(i >= 8));
    end
    do_reset();
    sh = '1;
    last = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        step(8'($urandom), 1'b0, 1'b0);
        chk("lb_gap_valid", 8'(data_out_valid), 8'h00);
        chk("lb_gap_hold", data_out, last);
      end
      d = 8'($urandom);
      scr(d, r);
      step(r, 1'b1, 1'b0);
      chk($sformatf("lb_data%0d", i), data_out, d);
      chk("lb_valid", 8'(data_out_valid), 8'h01);
      last = d;
    end
`ifdef LFSR_DESCRAMBLE_BYPASS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bypass = (i < 4);
      step(8'h00, 1'b1, 1'b0);
      chk($sformatf("byp_data%0d", i), data_out, t1[i]);
      chk($sformatf("byp_lock%0d", i), 8'(data_out_locked), 8'(i >= 8));
    end
    bypass = 1'b0;
`endif
    step(8'h00, 1'b0, 1'b0);
    chk("end_valid", 8'(data_out_valid), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
